// File: rtl/stage_id_scoreboard.sv
// stage_id_scoreboard
// ID-stage hazard scoreboard for long-latency writers (load, mul/div, FP).
// A register becomes pending when a long op writing it is accepted, and it
// stays pending until one of the NUM_WB writeback channels retires it.
// The ID stage stalls on a RAW or WAW hit against a pending register, or
// when a new long op would exceed the outstanding-op limit.
// A saturating counter records how many cycles the stage spent stalled.

module stage_id_scoreboard #(
  parameter  int REG_NUM         = 32,
  parameter  int NUM_WB          = 2,
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int WB_BYPASS       = 1,
  parameter  int CNT_WIDTH       = 32,
  parameter  int ZERO_REG        = 1,
  localparam int AW              = $clog2(REG_NUM),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_long,
  input  logic                   has_rs1,
  input  logic                   has_rs2,
  input  logic                   has_rs3,
  input  logic [AW-1:0]          rs1_addr,
  input  logic [AW-1:0]          rs2_addr,
  input  logic [AW-1:0]          rs3_addr,
  input  logic [AW-1:0]          rd_addr,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_rd,
  input  logic                   flush,
  output logic                   stall,
  output logic [CW-1:0]          pending_count,
  output logic [CNT_WIDTH-1:0]   stall_cycles
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  // Architectural state.
  logic [REG_NUM-1:0]   pending_q;
  logic [REG_NUM-1:0]   pending_d;
  logic [CW-1:0]        pending_count_q;
  logic [CW-1:0]        pending_count_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q;
  logic [CNT_WIDTH-1:0] stall_cycles_d;

  // Per-cycle decode.
  logic [REG_NUM-1:0]   clr;
  logic [REG_NUM-1:0]   peff;
  logic [CW-1:0]        cleared_cnt;
  logic [CW-1:0]        count_after_clr;
  logic                 rd_trackable;
  logic                 raw_hit;
  logic                 waw_hit;
  logic                 cap_hit;
  logic                 stall_int;
  logic                 accept;
  logic                 set_new;

  // An index can be tracked if it names a real register and is not the
  // hardwired zero register.
  function automatic logic reg_trackable(input logic [AW-1:0] addr);
    logic ok;
    ok = (int'(addr) < REG_NUM);
    if ((ZERO_REG != 0) && (addr == '0)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Look up one bit of a per-register vector, treating untrackable indices
  // as never pending.
  function automatic logic vec_hit(input logic [REG_NUM-1:0] vec,
                                   input logic [AW-1:0]      addr);
    logic hit;
    hit = 1'b0;
    if (reg_trackable(addr)) begin
      hit = vec[addr];
    end
    return hit;
  endfunction

  // Decode the writeback channels into a per-register clear vector; several
  // channels naming the same register collapse into a single clear.
  always_comb begin
    clr = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      for (int ch = 0; ch < NUM_WB; ch++) begin
        if (wb_valid[ch] && (wb_rd[ch*AW +: AW] == AW'(r))) begin
          clr[r] = 1'b1;
        end
      end
    end
  end

  // Effective pending view used by the hazard checks; with bypass a
  // same-cycle writeback already hides the register.
  always_comb begin
    peff = pending_q;
    if (WB_BYPASS != 0) begin
      peff = pending_q & ~clr;
    end
  end

  // Count how many currently pending registers retire this cycle, so the
  // capacity check sees the occupancy left after writebacks.
  always_comb begin
    cleared_cnt = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      if (pending_q[r] && clr[r]) begin
        cleared_cnt = cleared_cnt + CW'(1);
      end
    end
    count_after_clr = pending_count_q - cleared_cnt;
  end

  // Hazard detection and the combinational stall decision.
  always_comb begin
    rd_trackable = reg_trackable(rd_addr);
    raw_hit      = (has_rs1 && vec_hit(peff, rs1_addr)) ||
                   (has_rs2 && vec_hit(peff, rs2_addr)) ||
                   (has_rs3 && vec_hit(peff, rs3_addr));
    waw_hit      = issue_long && vec_hit(peff, rd_addr);
    cap_hit      = issue_long && rd_trackable && (count_after_clr == MAX_CNT);
    stall_int    = issue_valid && (raw_hit || waw_hit || cap_hit);
    accept       = issue_valid && !stall_int && !flush;
    set_new      = accept && issue_long && rd_trackable;
  end

  // Next pending vector: retire cleared registers, then record the newly
  // accepted destination (a set beats a same-cycle clear); flush wipes all.
  always_comb begin
    pending_d = pending_q & ~clr;
    if (set_new) begin
      pending_d[rd_addr] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
    end
  end

  // Occupancy tracked incrementally. A set can only land on a register that
  // is not still pending after clears (the WAW check guarantees it), so it
  // always adds exactly one, and the capacity check keeps the sum in range.
  always_comb begin
    pending_count_d = count_after_clr;
    if (set_new) begin
      pending_count_d = count_after_clr + CW'(1);
    end
    if (flush) begin
      pending_count_d = '0;
    end
  end

  // Saturating stall-cycle counter; flush deliberately leaves it alone.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_int && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    end
  end

  // State registers with asynchronous reset dropping all tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q       <= '0;
      pending_count_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      pending_q       <= pending_d;
      pending_count_q <= pending_count_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign stall         = stall_int;
  assign pending_count = pending_count_q;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_stage_id_scoreboard.sv
// Bench for stage_id_scoreboard: directed vector table, hand-written
// multi-cycle sequences (saturation, async reset) and a randomized phase
// compared against a register-set reference model.

module tb_stage_id_scoreboard;

  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int MAXO = 8;

  typedef struct {
    bit        iv;
    bit        il;
    bit        h1;
    bit        h2;
    bit        h3;
    bit [4:0]  a1;
    bit [4:0]  a2;
    bit [4:0]  a3;
    bit [4:0]  rd;
    bit [1:0]  wbv;
    bit [4:0]  w0;
    bit [4:0]  w1;
    bit        fl;
    bit        expStall;
    int        expCount;
    int        expCycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_long;
  logic        has_rs1, has_rs2, has_rs3;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr, rd_addr;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        flush;
  logic        stall, stall_s;
  logic [3:0]  pending_count, pending_count_s;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles_s;

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending registers plus stall counters.
  bit     modelPend[NREG];
  longint modelCycles;

  vec_t vecs[$];

  always #5 clk = ~clk;

  stage_id_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_long(issue_long),
    .has_rs1(has_rs1), .has_rs2(has_rs2), .has_rs3(has_rs3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rd_addr(rd_addr), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .pending_count(pending_count), .stall_cycles(stall_cycles)
  );

  stage_id_scoreboard #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_long(issue_long),
    .has_rs1(has_rs1), .has_rs2(has_rs2), .has_rs3(has_rs3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rd_addr(rd_addr), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall_s), .pending_count(pending_count_s), .stall_cycles(stall_cycles_s)
  );

  function automatic vec_t mk(bit iv, bit il, bit h1, int a1, bit h2, int a2,
                              bit h3, int a3, int rd, bit [1:0] wbv, int w0,
                              int w1, bit fl, bit es, int ec, int ecy);
    vec_t v;
    v.iv = iv; v.il = il; v.h1 = h1; v.h2 = h2; v.h3 = h3;
    v.a1 = 5'(a1); v.a2 = 5'(a2); v.a3 = 5'(a3); v.rd = 5'(rd);
    v.wbv = wbv; v.w0 = 5'(w0); v.w1 = 5'(w1); v.fl = fl;
    v.expStall = es; v.expCount = ec; v.expCycles = ecy;
    return v;
  endfunction

  function automatic bit isClr(int r);
    for (int ch = 0; ch < 2; ch++) begin
      if (wb_valid[ch] && (int'(wb_rd[ch*AW +: AW]) == r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit effPend(int r);
    if (r == 0) return 1'b0;
    return modelPend[r] && !isClr(r);
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int r = 0; r < NREG; r++) if (modelPend[r]) n++;
    return n;
  endfunction

  function automatic int countAfterClears();
    int n = 0;
    for (int r = 0; r < NREG; r++) if (modelPend[r] && !isClr(r)) n++;
    return n;
  endfunction

  function automatic bit modelStall();
    if (!issue_valid) return 1'b0;
    if (has_rs1 && effPend(int'(rs1_addr))) return 1'b1;
    if (has_rs2 && effPend(int'(rs2_addr))) return 1'b1;
    if (has_rs3 && effPend(int'(rs3_addr))) return 1'b1;
    if (issue_long && rd_addr != 0 &&
        (effPend(int'(rd_addr)) || countAfterClears() == MAXO)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint satOf(longint c);
    return (c > 15) ? 64'd15 : c;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) modelPend[r] = 1'b0;
    modelCycles = 0;
  endtask

  // Advance the model by one clock edge using the inputs held over it.
  task automatic modelStep();
    bit st, acc;
    bit clrNow[NREG];
    st  = modelStall();
    acc = issue_valid && !st && !flush;
    for (int r = 0; r < NREG; r++) clrNow[r] = isClr(r);
    if (st && modelCycles < 64'hFFFF_FFFF) modelCycles++;
    if (flush) begin
      for (int r = 0; r < NREG; r++) modelPend[r] = 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) if (clrNow[r]) modelPend[r] = 1'b0;
      if (acc && issue_long && rd_addr != 0) modelPend[int'(rd_addr)] = 1'b1;
    end
  endtask

  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    issue_valid = v.iv; issue_long = v.il;
    has_rs1 = v.h1; has_rs2 = v.h2; has_rs3 = v.h3;
    rs1_addr = v.a1; rs2_addr = v.a2; rs3_addr = v.a3; rd_addr = v.rd;
    wb_valid = v.wbv; wb_rd = {v.w1, v.w0}; flush = v.fl;
  endtask

  task automatic checkOutput(input string tag, input bit expStall,
                             input int expCount, input longint expCycles);
    cmp({tag, " stall"},       64'(stall),          64'(expStall));
    cmp({tag, " count"},       64'(pending_count),  64'(expCount));
    cmp({tag, " cycles"},      64'(stall_cycles),   64'(expCycles));
    cmp({tag, " sat_cycles"},  64'(stall_cycles_s), 64'(satOf(expCycles)));
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, modelStall(), modelCount(), modelCycles);
  endtask

  // One cycle driven from a vector and compared against the model.
  task automatic modelCycle(input string tag, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkModel(tag);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    rst = 1'b1;
    idle = mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0);
    applyStimulus(idle);
    modelReset();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: iv,il,h1,a1,h2,a2,h3,a3,rd,wbv,w0,w1,fl, stall,count,cycles
    vecs.push_back(mk(1,0,1,5,0,0,0,0,0,2'b00,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,7,2'b00,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1,7,0,0,0,2'b00,0,0,0, 1,1,0));
    vecs.push_back(mk(1,0,0,0,1,7,0,0,0,2'b00,0,0,0, 1,1,1));
    vecs.push_back(mk(1,0,0,0,1,7,0,0,0,2'b00,0,0,0, 1,1,2));
    vecs.push_back(mk(1,0,0,0,1,7,0,0,0,2'b10,0,7,0, 0,1,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0, 0,0,3));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1,1,0,0,0,0,0,0,k,2'b00,0,0,0, 0,k-1,3));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,9,2'b00,0,0,0, 1,8,3));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,9,2'b01,3,0,0, 0,8,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0, 0,8,4));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,4,2'b00,0,0,0, 1,8,4));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,4,2'b01,4,0,0, 0,8,5));
    vecs.push_back(mk(1,0,1,4,0,0,0,0,0,2'b00,0,0,0, 1,8,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,1, 0,8,6));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,0,2'b00,0,0,0, 0,0,6));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,2'b00,0,0,0, 0,0,6));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,6,2'b00,0,0,0, 0,0,6));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,10,2'b00,0,0,0, 0,1,6));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,6,6,0, 0,2,6));
    vecs.push_back(mk(1,0,1,6,1,10,0,0,0,2'b00,0,0,0, 1,1,6));
    vecs.push_back(mk(1,1,0,0,0,0,1,6,11,2'b00,0,0,0, 0,1,7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,12,2'b00,0,0,0, 0,2,7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,13,2'b00,0,0,0, 0,3,7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,14,2'b00,0,0,0, 0,4,7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,15,2'b00,0,0,1, 0,5,7));
    vecs.push_back(mk(1,0,1,15,0,0,0,0,0,2'b00,0,0,0, 0,0,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,2'b01,20,0,0, 0,0,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0, 0,0,7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,3,2'b00,0,0,0, 0,0,7));
    vecs.push_back(mk(1,0,0,0,0,0,1,3,0,2'b00,0,0,0, 1,1,7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,3,2'b00,0,0,0, 1,1,8));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expStall,
                  vecs[i].expCount, longint'(vecs[i].expCycles));
      @(posedge clk);
      modelStep();
      #1;
    end

    // Hold a RAW stall long enough to saturate the 4-bit counter.
    v = mk(1,0,1,3,0,0,0,0,0,2'b00,0,0,0,0,0,0);
    for (int c = 0; c < 20; c++) modelCycle($sformatf("sat%0d", c), v);
    @(negedge clk);
    cmp("sat_hold", 64'(stall_cycles_s), 64'd15);
    @(posedge clk);
    modelStep();
    #1;

    // Reload more pending registers, then pulse reset between edges.
    modelCycle("reload20", mk(1,1,0,0,0,0,0,0,20,2'b00,0,0,0,0,0,0));
    modelCycle("reload21", mk(1,1,0,0,0,0,0,0,21,2'b00,0,0,0,0,0,0));
    applyStimulus(v);
    @(negedge clk);
    cmp("pre_rst_count", 64'(pending_count), 64'd3);
    #1 rst = 1'b1;
    #1;
    cmp("async_rst_count", 64'(pending_count), 64'd0);
    cmp("async_rst_cycles", 64'(stall_cycles), 64'd0);
    cmp("async_rst_sat", 64'(stall_cycles_s), 64'd0);
    cmp("async_rst_stall", 64'(stall), 64'd0);
    modelReset();
    #1 rst = 1'b0;
    @(posedge clk);
    modelStep();
    #1;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      v.iv  = ($urandom_range(0, 3) != 0);
      v.il  = 1'($urandom_range(0, 1));
      v.h1  = 1'($urandom_range(0, 1));
      v.h2  = 1'($urandom_range(0, 1));
      v.h3  = ($urandom_range(0, 3) == 0);
      v.a1  = 5'($urandom_range(0, 15));
      v.a2  = 5'($urandom_range(0, 15));
      v.a3  = 5'($urandom_range(0, 15));
      v.rd  = 5'($urandom_range(0, 15));
      v.wbv = 2'($urandom_range(0, 3));
      v.w0  = 5'($urandom_range(0, 15));
      v.w1  = ($urandom_range(0, 3) == 0) ? v.w0 : 5'($urandom_range(0, 15));
      v.fl  = ($urandom_range(0, 63) == 0);
      modelCycle($sformatf("rand%0d", c), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
